axi_readn_arbiter: RTL and testbench

- Shares one downstream burst-read port (araddr/arlenw/R channel, same shape as the axi_readn caller side) among NUM_REQ burst-read requesters.
- Grants are round-robin and locked for a whole burst, from AR handshake through the rlast handshake.
- Sits between several frame-buffer line readers and a single axi_readn instance, or a striped reader.

---
 rtl/axi_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 53 +++++
 rtl/axi_readn_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_readn_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the burst-read arbiter.
package axi_arb_pkg;

  // Arbiter FSM states: waiting for a request, presenting the address, streaming beats.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of a request vector against a rotating priority pointer.
// The pointer moves to one past the index that just won, wrapping at NUM_REQ.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  input  logic [IW-1:0]      adv_idx_i,
  output logic [IW-1:0]      pick_o,
  output logic               any_req_o
);

  localparam logic [IW:0]   NUM_REQ_W = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_d;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [IW-1:0]        off;
  logic [IW:0]          sum;

  // First requester at or after the pointer: rotate the doubled vector, find the
  // lowest set bit, then add the pointer back modulo NUM_REQ.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_q;
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_dbl[k]) off = IW'(k);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
    pick_o    = sum[IW-1:0];
    any_req_o = |req_i;
  end

  // Next pointer: one past the winner, wrapping at NUM_REQ (not a power of two).
  assign ptr_d = (adv_idx_i == LAST_IDX) ? '0 : adv_idx_i + IW'(1);

  // Pointer register, advanced only when a granted address is accepted downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axi_readn_arbiter.sv
// Shares one downstream burst-read port among NUM_REQ requesters. A grant is held
// from the AR handshake through the rlast handshake; the end of a burst is taken
// from rlast only, arlenw is passed through and never counted.
//
// Handshakes: every channel transfers on a cycle where valid and ready are both
// high. Address and R channels of the granted requester are wired straight
// through combinationally, so beats can flow every cycle with no bubble. Ungranted
// requesters see arready/rvalid/rlast held at 0 and their requests stay pending.
module axi_readn_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int AXI_ADDR_WIDTH   = 20,
  parameter int AXI_DATA_WIDTH   = 16,
  parameter int AXI_ARLENW_WIDTH = 8
) (
  input  logic                                 axi_clk,
  input  logic                                 axi_resetn,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]    in_axi_araddr,
  input  logic [NUM_REQ*AXI_ARLENW_WIDTH-1:0]  in_axi_arlenw,
  input  logic [NUM_REQ-1:0]                   in_axi_arvalid,
  output logic [NUM_REQ-1:0]                   in_axi_arready,
  output logic [NUM_REQ*AXI_DATA_WIDTH-1:0]    in_axi_rdata,
  output logic [NUM_REQ*2-1:0]                 in_axi_rresp,
  output logic [NUM_REQ-1:0]                   in_axi_rvalid,
  output logic [NUM_REQ-1:0]                   in_axi_rlast,
  input  logic [NUM_REQ-1:0]                   in_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0]            out_axi_araddr,
  output logic [AXI_ARLENW_WIDTH-1:0]          out_axi_arlenw,
  output logic                                 out_axi_arvalid,
  input  logic                                 out_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]            out_axi_rdata,
  input  logic [1:0]                           out_axi_rresp,
  input  logic                                 out_axi_rvalid,
  input  logic                                 out_axi_rlast,
  output logic                                 out_axi_rready,
  output logic [1:0]                           dbg_state_o
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int LW = AXI_ARLENW_WIDTH;

  arb_state_e    state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          sel_arvalid;
  logic          sel_rready;
  logic          ar_hs;
  logic          burst_done;

  logic [AW-1:0] req_addr [NUM_REQ];
  logic [LW-1:0] req_len  [NUM_REQ];

  // Split the flat per-requester address/length buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i] = in_axi_araddr[i*AW +: AW];
      req_len[i]  = in_axi_arlenw[i*LW +: LW];
    end
  end

  assign sel_arvalid = in_axi_arvalid[grant_q];
  assign sel_rready  = in_axi_rready[grant_q];
  assign ar_hs       = (state_q == ADDR) && sel_arvalid && out_axi_arready;
  assign burst_done  = (state_q == DATA) && out_axi_rvalid && sel_rready && out_axi_rlast;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk_i     (axi_clk),
    .rst_ni    (axi_resetn),
    .req_i     (in_axi_arvalid),
    .advance_i (ar_hs),
    .adv_idx_i (grant_q),
    .pick_o    (pick),
    .any_req_o (any_req)
  );

  // Grant FSM: register the pick in IDLE, hold it until the rlast handshake.
  // A granted requester withdrawing arvalid in ADDR aborts back to IDLE and
  // leaves the pointer where it was.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (!sel_arvalid) begin
            state_q <= IDLE;
          end else if (out_axi_arready) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (burst_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Route handshake signals between the granted slice and the downstream port.
  always_comb begin
    in_axi_arready  = '0;
    in_axi_rvalid   = '0;
    in_axi_rlast    = '0;
    out_axi_arvalid = 1'b0;
    out_axi_rready  = 1'b0;
    case (state_q)
      ADDR: begin
        out_axi_arvalid         = sel_arvalid;
        in_axi_arready[grant_q] = out_axi_arready;
      end
      DATA: begin
        in_axi_rvalid[grant_q] = out_axi_rvalid;
        in_axi_rlast[grant_q]  = out_axi_rlast;
        out_axi_rready         = sel_rready;
      end
      default: ;
    endcase
  end

  assign out_axi_araddr = req_addr[grant_q];
  assign out_axi_arlenw = req_len[grant_q];

  // Data and response are broadcast unqualified; only the granted rvalid marks them.
  assign in_axi_rdata = {NUM_REQ{out_axi_rdata}};
  assign in_axi_rresp = {NUM_REQ{out_axi_rresp}};

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_readn_arbiter.sv
// Directed bench for axi_readn_arbiter with three requesters and a simple
// downstream responder returning (araddr + beat) as data.
module tb_axi_readn_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int LW = 8;

  logic              axi_clk;
  logic              axi_resetn;
  logic [N*AW-1:0]   in_axi_araddr;
  logic [N*LW-1:0]   in_axi_arlenw;
  logic [N-1:0]      in_axi_arvalid;
  logic [N-1:0]      in_axi_arready;
  logic [N*DW-1:0]   in_axi_rdata;
  logic [N*2-1:0]    in_axi_rresp;
  logic [N-1:0]      in_axi_rvalid;
  logic [N-1:0]      in_axi_rlast;
  logic [N-1:0]      in_axi_rready;
  logic [AW-1:0]     out_axi_araddr;
  logic [LW-1:0]     out_axi_arlenw;
  logic              out_axi_arvalid;
  logic              out_axi_arready;
  logic [DW-1:0]     out_axi_rdata;
  logic [1:0]        out_axi_rresp;
  logic              out_axi_rvalid;
  logic              out_axi_rlast;
  logic              out_axi_rready;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [AW-1:0] base_addr [N];
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] mask;
    int           len;
    int           exp_g;
  } vec_t;
  vec_t tbl [14];

  axi_readn_arbiter #(
    .NUM_REQ          (N),
    .AXI_ADDR_WIDTH   (AW),
    .AXI_DATA_WIDTH   (DW),
    .AXI_ARLENW_WIDTH (LW)
  ) dut (
    .axi_clk         (axi_clk),
    .axi_resetn      (axi_resetn),
    .in_axi_araddr   (in_axi_araddr),
    .in_axi_arlenw   (in_axi_arlenw),
    .in_axi_arvalid  (in_axi_arvalid),
    .in_axi_arready  (in_axi_arready),
    .in_axi_rdata    (in_axi_rdata),
    .in_axi_rresp    (in_axi_rresp),
    .in_axi_rvalid   (in_axi_rvalid),
    .in_axi_rlast    (in_axi_rlast),
    .in_axi_rready   (in_axi_rready),
    .out_axi_araddr  (out_axi_araddr),
    .out_axi_arlenw  (out_axi_arlenw),
    .out_axi_arvalid (out_axi_arvalid),
    .out_axi_arready (out_axi_arready),
    .out_axi_rdata   (out_axi_rdata),
    .out_axi_rresp   (out_axi_rresp),
    .out_axi_rvalid  (out_axi_rvalid),
    .out_axi_rlast   (out_axi_rlast),
    .out_axi_rready  (out_axi_rready),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  always @(posedge axi_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no finish, required finish before 200000ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- downstream responder ----------------
  logic [AW-1:0] sl_addr, s_a;
  logic [LW-1:0] sl_len, s_l, sl_k;
  bit            s_ar, s_r;

  initial begin
    out_axi_rvalid = 1'b0;
    out_axi_rlast  = 1'b0;
    out_axi_rdata  = '0;
    out_axi_rresp  = 2'b00;
    sl_addr = '0;
    sl_len  = '0;
    sl_k    = '0;
    forever begin
      @(negedge axi_clk);
      s_ar = out_axi_arvalid && out_axi_arready;
      s_r  = out_axi_rvalid && out_axi_rready;
      s_a  = out_axi_araddr;
      s_l  = out_axi_arlenw;
      @(posedge axi_clk);
      #1;
      if (!axi_resetn) begin
        out_axi_rvalid = 1'b0;
        out_axi_rlast  = 1'b0;
      end else if (s_ar) begin
        sl_addr        = s_a;
        sl_len         = s_l;
        sl_k           = '0;
        out_axi_rvalid = 1'b1;
        out_axi_rdata  = s_a[DW-1:0];
        out_axi_rresp  = 2'b00;
        out_axi_rlast  = (s_l == '0);
      end else if (s_r) begin
        if (out_axi_rlast) begin
          out_axi_rvalid = 1'b0;
          out_axi_rlast  = 1'b0;
        end else begin
          sl_k           = sl_k + LW'(1);
          out_axi_rdata  = sl_addr[DW-1:0] + DW'(sl_k);
          out_axi_rresp  = sl_k[1:0];
          out_axi_rlast  = (sl_k == sl_len);
        end
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a, input int l);
    in_axi_araddr[r*AW +: AW] = a;
    in_axi_arlenw[r*LW +: LW] = LW'(l);
    base_addr[r] = a;
  endtask

  // Waits for the AR handshake of requester r, then consumes its burst,
  // scoreboarding data/rlast and watching the other slices stay quiet.
  task automatic do_burst(input int r, input int len, input bit tog,
                          output int ar_cyc, output int last_cyc);
    logic [N-1:0]  oh;
    logic [DW-1:0] e;
    bit            got, done;
    int            beats, rdy_err, oth_err;
    oh = '0;
    oh[r] = 1'b1;
    got = 1'b0;
    ar_cyc = 0;
    last_cyc = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge axi_clk);
      if (out_axi_arvalid && out_axi_arready) begin
        got = 1'b1;
        break;
      end
    end
    check("ar_handshake_seen", 32'(got), 32'd1);
    ar_cyc = cyc;
    check("ar_grant_onehot", 32'(in_axi_arready), 32'(oh));
    check("ar_addr", 32'(out_axi_araddr), 32'(base_addr[r]));
    check("ar_len", 32'(out_axi_arlenw), 32'(len));
    for (int k = 0; k <= len; k++) exp_q.push_back(base_addr[r][DW-1:0] + DW'(k));
    @(posedge axi_clk);
    #1;
    in_axi_arvalid[r] = 1'b0;
    if (tog) in_axi_rready[r] = 1'b0;
    beats = 0;
    done = 1'b0;
    rdy_err = 0;
    oth_err = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      if (tog) in_axi_rready[r] = ~in_axi_rready[r];
      @(negedge axi_clk);
      if (out_axi_rready !== in_axi_rready[r]) rdy_err++;
      if ((((in_axi_rvalid | in_axi_rlast) & ~oh) != '0) || (in_axi_arready != '0)) oth_err++;
      if (in_axi_rvalid[r] && in_axi_rready[r]) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(beats), 32'(len + 1));
          done = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check("rdata", 32'(in_axi_rdata[r*DW +: DW]), 32'(e));
          check("rresp_bcast", 32'(in_axi_rresp), 32'({N{out_axi_rresp}}));
          check("rlast", 32'(in_axi_rlast[r]), 32'(exp_q.size() == 0));
          if (in_axi_rlast[r]) begin
            done = 1'b1;
            last_cyc = cyc;
          end
        end
      end
      @(posedge axi_clk);
      #1;
    end
    check("burst_done", 32'(done), 32'd1);
    check("beat_count", 32'(beats), 32'(len + 1));
    check("rready_mirror", 32'(rdy_err), 32'd0);
    check("other_slices_quiet", 32'(oth_err), 32'd0);
    exp_q.delete();
    in_axi_rready[r] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int  ar_c, last_c, ar_c2, last_c2, req_cyc, prev_last, beats;
  bit  got, seen2;

  initial begin
    // mask, len, expected grant (pointer starts at 0 and moves to grant+1 mod 3)
    tbl[0]  = '{3'b001, 3, 0};
    tbl[1]  = '{3'b111, 0, 1};
    tbl[2]  = '{3'b111, 0, 2};
    tbl[3]  = '{3'b111, 0, 0};
    tbl[4]  = '{3'b111, 0, 1};
    tbl[5]  = '{3'b111, 0, 2};
    tbl[6]  = '{3'b111, 0, 0};
    tbl[7]  = '{3'b101, 0, 2};
    tbl[8]  = '{3'b101, 0, 0};
    tbl[9]  = '{3'b010, 0, 1};
    tbl[10] = '{3'b010, 0, 1};
    tbl[11] = '{3'b011, 0, 0};
    tbl[12] = '{3'b100, 0, 2};
    tbl[13] = '{3'b110, 2, 1};

    axi_resetn      = 1'b0;
    in_axi_araddr   = '0;
    in_axi_arlenw   = '0;
    in_axi_arvalid  = '1;
    in_axi_rready   = '1;
    out_axi_arready = 1'b1;
    prev_last       = 0;
    for (int j = 0; j < N; j++) set_req(j, AW'((j + 1) * 'h100), 0);

    // Reset state, with every request and rready asserted.
    #12;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_in_arready", 32'(in_axi_arready), 32'd0);
    check("rst_in_rvalid", 32'(in_axi_rvalid), 32'd0);
    check("rst_in_rlast", 32'(in_axi_rlast), 32'd0);
    check("rst_out_arvalid", 32'(out_axi_arvalid), 32'd0);
    check("rst_out_rready", 32'(out_axi_rready), 32'd0);
    in_axi_arvalid = '0;
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    @(posedge axi_clk);
    #1;

    // Table: grant order, latency, gap between bursts.
    for (int i = 0; i < 14; i++) begin
      for (int j = 0; j < N; j++) set_req(j, AW'((j + 1) * 'h100), tbl[i].len);
      in_axi_arvalid = tbl[i].mask;
      req_cyc = cyc;
      do_burst(tbl[i].exp_g, tbl[i].len, 1'b0, ar_c, last_c);
      check("grant_latency", 32'(ar_c - req_cyc), 32'd1);
      if (i > 0) check("burst_gap", 32'(ar_c - prev_last), 32'd2);
      check("idle_after_burst", 32'(dbg_state), 32'd0);
      prev_last = last_c;
    end
    in_axi_arvalid = '0;

    // req1 arrives mid-burst of req0 (8 beats, rready toggling); req1 is next.
    set_req(0, 20'h000A0, 7);
    set_req(1, 20'h00200, 0);
    in_axi_rready  = '1;
    in_axi_arvalid = 3'b001;
    fork
      do_burst(0, 7, 1'b1, ar_c, last_c);
      begin
        repeat (4) @(posedge axi_clk);
        #1;
        in_axi_arvalid[1] = 1'b1;
      end
    join
    do_burst(1, 0, 1'b0, ar_c2, last_c2);
    check("pending_gap", 32'(ar_c2 - last_c), 32'd2);

    // Granted requester withdraws in ADDR: abort, pointer stays at 2.
    out_axi_arready = 1'b0;
    set_req(0, 20'h00100, 0);
    set_req(2, 20'h00300, 0);
    in_axi_arvalid = 3'b100;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge axi_clk);
      if (out_axi_arvalid) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_ar_seen", 32'(got), 32'd1);
    check("abort_arready_zero", 32'(in_axi_arready), 32'd0);
    check("abort_addr", 32'(out_axi_araddr), 32'h300);
    @(posedge axi_clk);
    #1;
    in_axi_arvalid = '0;
    @(negedge axi_clk);
    check("abort_arvalid_drops", 32'(out_axi_arvalid), 32'd0);
    @(negedge axi_clk);
    check("abort_back_to_idle", 32'(dbg_state), 32'd0);
    check("abort_no_arvalid", 32'(out_axi_arvalid), 32'd0);
    @(posedge axi_clk);
    #1;
    out_axi_arready = 1'b1;
    in_axi_arvalid  = 3'b101;
    do_burst(2, 0, 1'b0, ar_c, last_c);
    in_axi_arvalid = '0;

    // Asynchronous reset during beat 2 of a 4-beat burst from req1.
    set_req(1, 20'h00400, 3);
    in_axi_arvalid = 3'b010;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge axi_clk);
      if (out_axi_arvalid && out_axi_arready) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_seq_ar_seen", 32'(got), 32'd1);
    check("rst_seq_grant", 32'(in_axi_arready), 32'b010);
    @(posedge axi_clk);
    #1;
    in_axi_arvalid = '0;
    beats = 0;
    seen2 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge axi_clk);
      if (in_axi_rvalid[1] && beats == 1) begin
        seen2 = 1'b1;
        break;
      end
      if (in_axi_rvalid[1] && in_axi_rready[1]) beats++;
    end
    check("rst_seq_beat2_seen", 32'(seen2), 32'd1);
    check("rst_seq_beat2_data", 32'(in_axi_rdata[DW +: DW]), 32'h401);
    #2;
    axi_resetn = 1'b0;
    #1;
    check("async_rst_state", 32'(dbg_state), 32'd0);
    check("async_rst_rvalid", 32'(in_axi_rvalid), 32'd0);
    check("async_rst_rlast", 32'(in_axi_rlast), 32'd0);
    check("async_rst_out_rready", 32'(out_axi_rready), 32'd0);
    check("async_rst_arready", 32'(in_axi_arready), 32'd0);
    check("async_rst_out_arvalid", 32'(out_axi_arvalid), 32'd0);
    @(posedge axi_clk);
    @(posedge axi_clk);
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    @(posedge axi_clk);
    #1;
    set_req(1, 20'h00500, 1);
    in_axi_arvalid = 3'b010;
    req_cyc = cyc;
    do_burst(1, 1, 1'b0, ar_c, last_c);
    check("post_rst_latency", 32'(ar_c - req_cyc), 32'd1);
    in_axi_arvalid = '0;

    repeat (3) @(posedge axi_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
